// File: rtl/risc_ctrl.sv
// Multicycle sequencer for the 8-bit accumulator RISC CPU: steps the 8-phase
// fetch/execute cycle, decodes datapath strobes, tracks halt and retired count.
module risc_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e           phase_q, phase_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

  always_comb begin
    is_hlt   = (opcode == OP_HLT);
    is_skz   = (opcode == OP_SKZ);
    is_sto   = (opcode == OP_STO);
    is_jmp   = (opcode == OP_JMP);
    is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (!halted_q) begin
      if (phase_q == OP_ADDR && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
        if (phase_q == STORE) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = !is_hlt;
          halt   = is_hlt;
        end
        OP_FETCH: rd = is_aluop;
        ALU_OP: begin
          rd     = is_aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          // SKZ also strobes inc_pc here; the datapath counts only this edge.
          rd     = is_aluop;
          ld_ac  = is_aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_ctrl.sv
// Self-checking bench for risc_ctrl: per-opcode phase-mask vectors fed through
// a scoreboard queue, plus hand-written halt, wrap and async-reset sequences.
module tb_risc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  logic [7:0] instr_cnt;

  risc_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Each mask holds one bit per phase: bit i set = strobe high in phase i.
  typedef struct packed {
    logic [2:0] op;
    logic       z;
    logic [7:0] rd_m;
    logic [7:0] inc_m;
    logic [7:0] ldpc_m;
    logic [7:0] ldac_m;
    logic [7:0] wr_m;
    logic [7:0] de_m;
    logic [7:0] halt_m;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  model_cnt;
  logic        watch_wr = 1'b0;
  logic        wr_seen  = 1'b0;

  localparam logic [11:0] RESET_OUT  = {3'd0, 1'b0, 1'b1, 7'b0};
  localparam logic [11:0] HALTED_OUT = {3'd4, 1'b1, 8'b0};

  always @(wr) if (watch_wr && wr) wr_seen = 1'b1;

  function automatic logic [11:0] act_out();
    return {phase, halt, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
  endfunction

  function automatic logic [11:0] exp_out(input int p, input vec_t v);
    logic [7:0] sel_m, ldir_m;
    sel_m  = 8'h0F;
    ldir_m = 8'h0C;
    return {p[2:0], v.halt_m[p], sel_m[p], v.rd_m[p], ldir_m[p], v.inc_m[p],
            v.ldpc_m[p], v.ldac_m[p], v.wr_m[p], v.de_m[p]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after a negedge with the DUT in phase p; ends at the next negedge.
  task automatic step(input int p, input vec_t v);
    opcode = v.op;
    zero   = v.z;
    exp_q.push_back(exp_out(p, v));
    #1;
    check($sformatf("op%0d_z%0d_ph%0d", v.op, v.z, p), {20'b0, act_out()}, {20'b0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_out", {20'b0, act_out()}, {20'b0, RESET_OUT});
    check("reset_cnt", {24'b0, instr_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 8'd0;
  endtask

  vec_t vecs[10];
  vec_t v_hlt, v_sto;

  initial begin
    //            op    z     rd     inc    ldpc   ldac   wr     de     halt
    vecs[0] = '{3'd2, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00}; // ADD
    vecs[1] = '{3'd2, 1'b1, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00}; // ADD z
    vecs[2] = '{3'd3, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00}; // AND
    vecs[3] = '{3'd4, 1'b1, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00}; // XOR
    vecs[4] = '{3'd5, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00}; // LDA
    vecs[5] = '{3'd6, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0, 8'h00}; // STO
    vecs[6] = '{3'd1, 1'b1, 8'h0E, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; // SKZ z
    vecs[7] = '{3'd1, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; // SKZ
    vecs[8] = '{3'd7, 1'b1, 8'h0E, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00}; // JMP
    vecs[9] = '{3'd6, 1'b1, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0, 8'h00}; // STO z
    v_hlt   = '{3'd0, 1'b0, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    v_sto   = vecs[5];

    opcode = 3'd2;
    zero   = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      for (int p = 0; p < 8; p++) step(p, vecs[i]);
      model_cnt = model_cnt + 8'd1;
      check($sformatf("cnt_after_vec%0d", i), {24'b0, instr_cnt}, {24'b0, model_cnt});
    end

    // HLT: normal fetch, halt in phase 4, then frozen regardless of opcode.
    for (int p = 0; p < 5; p++) step(p, v_hlt);
    for (int c = 0; c < 24; c++) begin
      if (c == 6) opcode = 3'd2;
      if (c == 12) zero = 1'b1;
      #1;
      check($sformatf("halted_c%0d", c), {20'b0, act_out()}, {20'b0, HALTED_OUT});
      @(negedge clk);
    end
    check("halted_cnt", {24'b0, instr_cnt}, {24'b0, model_cnt});
    #3;
    do_reset();
    check("post_halt_phase", {29'b0, phase}, 32'd0);

    // Counter wrap over 256 retired instructions.
    opcode = 3'd2;
    zero   = 1'b0;
    repeat (255 * 8) @(negedge clk);
    check("cnt_255", {24'b0, instr_cnt}, 32'd255);
    repeat (8) @(negedge clk);
    #1;
    check("cnt_wrap", {24'b0, instr_cnt}, 32'd0);
    check("wrap_phase", {29'b0, phase}, 32'd0);

    // Async reset in phase 6 of STO: outputs drop at once, wr never rises.
    @(negedge clk);
    do_reset();
    watch_wr = 1'b1;
    for (int p = 0; p < 6; p++) step(p, v_sto);
    #1;
    check("sto_ph6_de", {31'b0, data_e}, 32'd1);
    reset = 1'b1;
    #1;
    check("sto_rst_out", {20'b0, act_out()}, {20'b0, RESET_OUT});
    @(negedge clk);
    #1;
    check("sto_rst_hold", {20'b0, act_out()}, {20'b0, RESET_OUT});
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("sto_first_edge", {29'b0, phase}, 32'd1);
    watch_wr = 1'b0;
    check("sto_no_wr", {31'b0, wr_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
